// File: rtl/osc_bank.sv
// osc_bank: a bank of independent programmable oscillators.
// Each channel keeps a pending configuration (period, high time,
// burst count, mode). On Start it copies that configuration into its
// active set and produces a registered square wave. A pending write
// made while the channel runs is applied only at a period boundary.
// Burst channels stop after B periods and pulse Done for one cycle.
// Continuous channels run until Stop or Rst.

module osc_bank #(
    parameter int CH = 4,
    parameter int CW = 16,
    parameter int BW = 8
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    input  logic [CH-1:0]                        Start,
    input  logic [CH-1:0]                        Stop,
    input  logic                                 Cfg_we,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] Cfg_ch,
    input  logic [CW-1:0]                        Cfg_period,
    input  logic [CW-1:0]                        Cfg_high,
    input  logic [BW-1:0]                        Cfg_burst,
    input  logic                                 Cfg_mode,
    output logic [CH-1:0]                        Tout,
    output logic [CH-1:0]                        Busy,
    output logic [CH-1:0]                        Done
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    // Default configuration: a 2-cycle period with 1 high cycle gives a
    // toggling output. One burst period. Continuous mode.
    localparam logic [CW-1:0] DEF_P = CW'(2);
    localparam logic [CW-1:0] DEF_H = CW'(1);
    localparam logic [BW-1:0] DEF_B = BW'(1);
    localparam logic          DEF_M = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    for (genvar g = 0; g < CH; g++) begin : g_ch

        state_t        state_q, state_d;

        // Pending configuration, written by the config port.
        logic [CW-1:0] pend_p, pend_h;
        logic [BW-1:0] pend_b;
        logic          pend_m;

        // Active configuration, used by the running waveform.
        logic [CW-1:0] act_p, act_h;
        logic [BW-1:0] act_b;
        logic          act_m;

        // Pending configuration with a write in this cycle merged in.
        logic [CW-1:0] nxt_p, nxt_h;
        logic [BW-1:0] nxt_b;
        logic          nxt_m;

        logic [CW-1:0] cnt_q, cnt_d;
        logic [BW-1:0] pc_q, pc_d;
        logic          tout_q, tout_d;
        logic          done_q, done_d;

        logic          sel;
        logic          go;
        logic          load;
        logic          wrap;
        logic          burst_end;
        logic [CW-1:0] p_last;
        logic [BW-1:0] b_last;
        logic [CW-1:0] h_sel;

        // An index of CH or higher matches no channel, so that write is dropped.
        assign sel = Cfg_we && (Cfg_ch == CHW'(g));

        assign nxt_p = sel ? Cfg_period : pend_p;
        assign nxt_h = sel ? Cfg_high   : pend_h;
        assign nxt_b = sel ? Cfg_burst  : pend_b;
        assign nxt_m = sel ? Cfg_mode   : pend_m;

        // Start is accepted only from IDLE, and Stop overrides it.
        assign go = Start[g] && !Stop[g];

        // The effective period is at least 2. The last count value is P_eff-1.
        assign p_last = (act_p < DEF_P) ? CW'(1) : act_p - CW'(1);

        // The effective burst length is at least 1. A burst ends on the wrap
        // that closes period B_eff.
        assign b_last    = (act_b == '0) ? '0 : act_b - BW'(1);
        assign wrap      = (cnt_q == p_last);
        assign burst_end = act_m && (pc_q >= b_last);

        // Pending config register: written by the config port only.
        always_ff @(posedge Clk) begin
            // NOTE: sequential state is assigned with <= so that every
            // register in this edge sees the pre-edge values.
            if (Rst) begin
                // NOTE: the configuration registers are reset because the
                // default waveform after reset is observable behaviour.
                pend_p <= DEF_P;
                pend_h <= DEF_H;
                pend_b <= DEF_B;
                pend_m <= DEF_M;
            end else if (sel) begin
                pend_p <= Cfg_period;
                pend_h <= Cfg_high;
                pend_b <= Cfg_burst;
                pend_m <= Cfg_mode;
            end
        end

        // State register for the per-channel IDLE/RUN machine.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next-state logic: start from IDLE, leave RUN on Stop or burst end.
        always_comb begin
            // NOTE: every combinational output gets a default first so that
            // no path through the block leaves it unassigned, which would
            // infer a latch.
            state_d = state_q;
            unique case (state_q)
                IDLE: if (go) state_d = RUN;
                RUN:  if (Stop[g] || (wrap && burst_end)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Datapath and output logic: counters, config load, Tout and Done.
        always_comb begin
            cnt_d  = cnt_q;
            pc_d   = pc_q;
            load   = 1'b0;
            done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    pc_d  = '0;
                    if (go) begin
                        load = 1'b1;
                    end
                end
                RUN: begin
                    if (Stop[g]) begin
                        cnt_d = '0;
                        pc_d  = '0;
                    end else if (wrap) begin
                        cnt_d = '0;
                        if (burst_end) begin
                            pc_d   = '0;
                            done_d = 1'b1;
                        end else begin
                            // The period boundary is the only point where a
                            // running channel takes new configuration.
                            load = 1'b1;
                            pc_d = (pc_q == '1) ? pc_q : pc_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                    pc_d  = '0;
                end
            endcase
            // Tout is registered, so it is computed from the counter value the
            // channel holds after this edge, using the config in force then.
            h_sel  = load ? nxt_h : act_h;
            tout_d = (state_d == RUN) && (cnt_d < h_sel);
        end

        // Datapath register: counters, active config and registered outputs.
        always_ff @(posedge Clk) begin
            if (Rst) begin
                cnt_q  <= '0;
                pc_q   <= '0;
                tout_q <= 1'b0;
                done_q <= 1'b0;
                act_p  <= DEF_P;
                act_h  <= DEF_H;
                act_b  <= DEF_B;
                act_m  <= DEF_M;
            end else begin
                cnt_q  <= cnt_d;
                pc_q   <= pc_d;
                tout_q <= tout_d;
                done_q <= done_d;
                if (load) begin
                    act_p <= nxt_p;
                    act_h <= nxt_h;
                    act_b <= nxt_b;
                    act_m <= nxt_m;
                end
            end
        end

        assign Tout[g] = tout_q;
        assign Busy[g] = (state_q == RUN);
        assign Done[g] = done_q;

    end : g_ch

endmodule

// File: doc/osc_bank.md
OSC_BANK -- requirements
Module: osc_bank

Interface
REQ-001 The block SHALL have parameter CH, default 4, meaning the number of independent oscillator channels (1..16).
REQ-002 The block SHALL have parameter CW, default 16, meaning the period/high-time counter width.
REQ-003 The block SHALL have parameter BW, default 8, meaning the burst-count width.
REQ-004 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port Start, input, CH bits, a per-channel start request, sampled each cycle.
REQ-007 The block SHALL have port Stop, input, CH bits, a per-channel abort request, sampled each cycle.
REQ-008 The block SHALL have port Cfg_we, input, 1 bit, the configuration write strobe.
REQ-009 The block SHALL have port Cfg_ch, input, clog2(CH) bits (min 1), the channel index of the configuration write.
REQ-010 The block SHALL have ports Cfg_period (input, CW bits, period in cycles), Cfg_high (input, CW bits, high time in cycles), Cfg_burst (input, BW bits, period count), and Cfg_mode (input, 1 bit, 0=continuous, 1=burst).
REQ-011 The block SHALL have port Tout, output, CH bits, the registered oscillator outputs.
REQ-012 The block SHALL have port Busy, output, CH bits, high while a channel is in RUN.
REQ-013 The block SHALL have port Done, output, CH bits, a one-cycle pulse when a burst completes.

Function
REQ-014 Each channel SHALL hold pending config registers (P, H, B, M) written when Cfg_we=1 and Cfg_ch selects it; Cfg_ch>=CH SHALL be ignored.
REQ-015 Each channel SHALL implement states IDLE and RUN, with a counter cnt (CW bits) and a period counter pc (BW bits).
REQ-016 IDLE->RUN SHALL occur on Start=1 and Stop=0: active config copied from pending (including a write in the same cycle to that channel), cnt=0, pc=0.
REQ-017 Start while in RUN SHALL be ignored.
REQ-018 Stop=1 SHALL force IDLE on the next edge with Tout=0 and no Done pulse; Stop SHALL win over simultaneous Start.
REQ-019 In RUN, Tout SHALL be registered as (cnt<H_eff); the first high cycle SHALL appear on the cycle after Start is sampled (latency 1).
REQ-020 P_eff SHALL be max(P,2); H=0 SHALL give Tout constantly 0, and H>=P_eff SHALL give Tout constantly 1 while running.
REQ-021 cnt SHALL increment each cycle and wrap to 0 after P_eff-1; at each wrap pc SHALL increment (saturating at all-ones in continuous mode).
REQ-022 Pending config writes during RUN SHALL take effect only at a wrap (period boundary), never mid-period.
REQ-023 In burst mode, with B_eff = max(B,1), the wrap completing period B_eff SHALL return the channel to IDLE, drive Tout=0, and pulse Done for exactly one cycle.
REQ-024 In continuous mode the channel SHALL run until Stop or Rst.
REQ-025 Channels SHALL be fully independent; all may start, stop or finish in the same cycle.

Reset
REQ-026 Rst=1 SHALL set all channels to IDLE, with Tout=0, Busy=0, Done=0, cnt=0, pc=0 on the next edge.
REQ-027 Rst SHALL reset pending config to P=2, H=1, B=1, M=0.
REQ-028 Rst SHALL override Start, Stop and Cfg_we in the same cycle, including mid-burst.

Verification
REQ-029 Scenario 1: ch0 configured with P=4, H=2, M=0, then Start[0] -> Tout[0] shows 1,1,0,0 repeating from the next cycle, with Busy[0]=1.
REQ-030 Scenario 2: ch1 configured with P=5, H=1, B=3, M=1, then Start -> exactly 3 high pulses in 15 cycles, then Done[1] is one cycle high, and Busy[1] and Tout[1] are 0 afterwards.
REQ-031 Scenario 3: ch0 running with P=4, rewritten mid-period to P=6, H=3 -> the current period completes at length 4, and the next period is 6 cycles long with 3 high.
REQ-032 Scenario 4: Start and Stop both asserted on ch2 in the same cycle -> ch2 stays IDLE; a later Stop during a burst -> Tout=0 and no Done pulse.
REQ-033 Scenario 5: edge configs P=0 (runs as P=2), H=0 (Tout constantly 0), H=P (Tout constantly 1), and B=0 (one period then Done) -> each behaves as specified.
REQ-034 Scenario 6: Rst asserted mid-burst on all channels -> all outputs are 0 the next cycle, and a subsequent Start uses the defaults P=2, H=1 (toggling output).
